// File: rtl/gb80_add16_seq.sv
// 16-bit ADD/ADC sequencer: runs the low byte, then the high byte, through a shared
// external 8-bit adder. Optional subtract support is enabled by macro GB80_ADD16_SUB_EN.
//
// state | meaning
// IDLE  | waiting for i_start; adder drive lines held at zero
// LO    | low bytes presented to the adder, low sum/carry captured on exit
// HI    | high bytes presented with low carry, result and flags captured on exit
// DONE  | o_done pulse; result and flags valid
module gb80_add16_seq #(
  parameter int BYTE_WIDTH = 8,
  parameter int WORD_WIDTH = 2 * BYTE_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_start,
  input  logic [WORD_WIDTH-1:0] i_op_a,
  input  logic [WORD_WIDTH-1:0] i_op_b,
  input  logic                  i_carry_in,
  input  logic                  i_sub,
  output logic [BYTE_WIDTH-1:0] o_add_a,
  output logic [BYTE_WIDTH-1:0] o_add_b,
  output logic                  o_add_cin,
  input  logic [BYTE_WIDTH-1:0] i_add_sum,
  input  logic                  i_add_cout,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [WORD_WIDTH-1:0] o_result,
  output logic                  o_flag_z,
  output logic                  o_flag_n,
  output logic                  o_flag_h,
  output logic                  o_flag_c
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                r_state;
  logic [BYTE_WIDTH-1:0] r_a_hi;
  logic [BYTE_WIDTH-1:0] r_b_hi;
  logic [BYTE_WIDTH-1:0] r_res_lo;
  logic                  r_sub;
  logic [BYTE_WIDTH-1:0] r_add_a;
  logic [BYTE_WIDTH-1:0] r_add_b;
  logic                  r_add_cin;
  logic                  r_busy;
  logic                  r_done;
  logic [WORD_WIDTH-1:0] r_result;
  logic                  r_flag_z;
  logic                  r_flag_n;
  logic                  r_flag_h;
  logic                  r_flag_c;

  logic                  w_sub;
  logic [WORD_WIDTH-1:0] w_b_eff;
  logic                  w_cin_eff;
  logic [4:0]            w_nib;
  logic [WORD_WIDTH-1:0] w_result;

`ifdef GB80_ADD16_SUB_EN
  // Subtract is A + ~B + ~cin: the carry input acts as an incoming borrow.
  assign w_sub     = i_sub;
  assign w_b_eff   = i_op_b ^ {WORD_WIDTH{i_sub}};
  assign w_cin_eff = i_carry_in ^ i_sub;
`else
  logic w_unused_sub;
  assign w_unused_sub = i_sub;
  assign w_sub        = 1'b0;
  assign w_b_eff      = i_op_b;
  assign w_cin_eff    = i_carry_in;
`endif

  // In HI the adder drive registers hold A[15:8], B'[15:8] and the low-byte carry.
  assign w_nib    = {1'b0, r_add_a[3:0]} + {1'b0, r_add_b[3:0]} + {4'b0, r_add_cin};
  assign w_result = {i_add_sum, r_res_lo};

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= IDLE;
      r_a_hi    <= '0;
      r_b_hi    <= '0;
      r_res_lo  <= '0;
      r_sub     <= 1'b0;
      r_add_a   <= '0;
      r_add_b   <= '0;
      r_add_cin <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_result  <= '0;
      r_flag_z  <= 1'b0;
      r_flag_n  <= 1'b0;
      r_flag_h  <= 1'b0;
      r_flag_c  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_a_hi    <= i_op_a[WORD_WIDTH-1:BYTE_WIDTH];
            r_b_hi    <= w_b_eff[WORD_WIDTH-1:BYTE_WIDTH];
            r_sub     <= w_sub;
            r_add_a   <= i_op_a[BYTE_WIDTH-1:0];
            r_add_b   <= w_b_eff[BYTE_WIDTH-1:0];
            r_add_cin <= w_cin_eff;
            r_busy    <= 1'b1;
            r_state   <= LO;
          end
        end
        LO: begin
          r_res_lo  <= i_add_sum;
          r_add_a   <= r_a_hi;
          r_add_b   <= r_b_hi;
          r_add_cin <= i_add_cout;
          r_state   <= HI;
        end
        HI: begin
          r_result  <= w_result;
          r_flag_z  <= (w_result == '0);
          r_flag_n  <= r_sub;
          r_flag_h  <= w_nib[4] ^ r_sub;
          r_flag_c  <= i_add_cout ^ r_sub;
          r_add_a   <= '0;
          r_add_b   <= '0;
          r_add_cin <= 1'b0;
          r_done    <= 1'b1;
          r_state   <= DONE;
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_add_a   = r_add_a;
  assign o_add_b   = r_add_b;
  assign o_add_cin = r_add_cin;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_result  = r_result;
  assign o_flag_z  = r_flag_z;
  assign o_flag_n  = r_flag_n;
  assign o_flag_h  = r_flag_h;
  assign o_flag_c  = r_flag_c;

endmodule

// File: doc/gb80_add16_seq.md
Name: gb80_add16_seq

Overview:
- Sequencer that performs 16-bit ADD/ADC (e.g. ADD HL,rr / ADD SP,e paths) on the shared 8-bit full adder.
- Sits directly upstream and downstream of the 8-bit adder:
  - drives its A/B/carry-in for the low byte, then the high byte;
  - registers its sum/carry-out between passes;
  - assembles the 16-bit result and Z/N/H/C flags for the register file and flag register.

Parameters:
- WORD_WIDTH, 16, result width; fixed at 2 × BYTE_WIDTH.
- BYTE_WIDTH, 8, width of the external adder slice.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_reset_n  input  1  asynchronous, active-low reset.
- i_start  input  1  request; accepted only while o_busy=0.
- i_op_a  input  16  operand A, sampled on the accepting edge.
- i_op_b  input  16  operand B, sampled on the accepting edge.
- i_carry_in  input  1  initial carry (ADC); 0 for plain ADD; sampled with operands.
- i_sub  input  1  subtract select; see Optional Feature.
- o_add_a  output  8  operand A byte to the external adder.
- o_add_b  output  8  operand B byte, inverted when subtracting.
- o_add_cin  output  1  carry to the external adder.
- i_add_sum  input  8  sum from the external adder, same cycle.
- i_add_cout  input  1  carry-out from the external adder, same cycle.
- o_busy  output  1  high from the accepting edge until o_done.
- o_done  output  1  one-cycle pulse; result and flags valid.
- o_result  output  16  registered result, held until the next accept.
- o_flag_z  output  1  result == 0x0000.
- o_flag_n  output  1  1 for subtract, else 0.
- o_flag_h  output  1  carry from bit 11 (add) or borrow into bit 12 (sub).
- o_flag_c  output  1  carry from bit 15 (add) or borrow (sub).

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE;
  - all outputs and internal registers = 0.
  - Asserting reset mid-operation aborts it: no o_done, result cleared.
- FSM states: IDLE → LO → HI → DONE → IDLE.
- IDLE:
  - o_add_* = 0.
  - On an edge with i_start=1: latch operands, i_carry_in, i_sub; go to LO; o_busy=1.
- LO:
  - Drive o_add_a=A[7:0], o_add_b=B'[7:0], o_add_cin=cin0.
  - B' = ~B when subtracting, else B.
  - cin0 = ~i_carry_in when subtracting, else i_carry_in.
  - On the edge: register i_add_sum into res[7:0] and i_add_cout into c_lo; go to HI.
- HI:
  - Drive o_add_a=A[15:8], o_add_b=B'[15:8], o_add_cin=c_lo.
  - Compute the internal 5-bit nibble sum A[11:8]+B'[11:8]+c_lo; its bit 4 is h_raw.
  - On the edge: register res[15:8], c_hi=i_add_cout, h_raw; go to DONE.
- DONE:
  - o_done=1 for exactly this cycle.
  - o_result, o_flag_z/n/h/c update on the DONE-entry edge:
    - H = h_raw XOR sub;
    - C = c_hi XOR sub.
  - o_busy deasserts on the edge leaving DONE; next state IDLE.
- Latency: accept on edge N → o_done high in the cycle after edge N+2 → next accept possible at edge N+4.
- i_start while o_busy=1 is ignored (not queued).
- i_start held high continuously → one operation per 4 cycles.
- Wrap-around: results are modulo 2^16; the carry is reported only via o_flag_c.
- o_result and flags are stable from DONE until the next accept.
- The external adder is combinational: this block never registers o_add_* outputs against i_add_* inputs within a state.

Optional Feature:
- Macro GB80_ADD16_SUB_EN.
- Defined:
  - i_sub is honoured: B is inverted, carry-in is inverted, and H/C are inverted to borrow sense;
  - o_flag_n = latched i_sub.
- Undefined:
  - i_sub is ignored (treated as 0);
  - o_flag_n is constant 0;
  - the inversion logic is not synthesized.

Test Plan:
- Plain add: A=0x00FF, B=0x0001, cin=0 → result 0x0100, Z=0, N=0, H=0, C=0; o_done exactly 3 cycles after accept.
- Half carry: A=0x0F00, B=0x0100 → result 0x1000, H=1, C=0, Z=0.
- Wrap: A=0xFFFF, B=0x0001 → result 0x0000, Z=1, H=1, C=1. Repeat with ADC: A=0xFFFF, B=0x0000, cin=1 → same result and flags.
- Subtract (GB80_ADD16_SUB_EN): A=0x1000, B=0x0001, sub=1 → result 0x0FFF, N=1, H=1, C=0. A=0x0000, B=0x0001 → result 0xFFFF, C=1, H=1.
- Busy and back-to-back: pulse i_start again during LO with different operands → ignored, first result delivered. i_start held high → o_done every 4th cycle with each newly sampled operand pair.
- Reset mid-op: deassert i_reset_n in the HI state → immediately state=IDLE, o_busy=0, o_result=0, no o_done. A new operation after release completes normally.
